// File: rtl/if_stage_pkg.sv
// Shared widths, reset constants and branch-bus layout for the IF stage.
// These values stand in for the mycpu.h constants.
package if_stage_pkg;

    localparam int BR_BUS_WD       = 33;
    localparam int FS_TO_DS_BUS_WD = 64;

    // Reset PC sits one word below the fetch vector so seq_pc lands on it.
    localparam logic [31:0] FS_RESET_PC     = 32'hbfbf_fffc;
    localparam logic [31:0] FETCH_RESET_VEC = 32'hbfc0_0000;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    function automatic logic [31:0] seq_pc_of(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// Instruction holding register: keeps the SRAM response alive across a decode stall.
module if_inst_buf
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_first,
    input  logic        fs_valid,
    input  logic        ds_allowin,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] fs_inst
);

    logic [31:0] inst_buf_q;
    logic        buf_valid_q;

    // Capture only in the response cycle; later SRAM output is not trusted.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_buf_q  <= '0;
            buf_valid_q <= 1'b0;
        end else if (fs_first && !ds_allowin) begin
            inst_buf_q  <= inst_sram_rdata;
            buf_valid_q <= 1'b1;
        end else if (fs_valid && ds_allowin) begin
            buf_valid_q <= 1'b0;
        end
    end

    assign fs_inst = buf_valid_q ? inst_buf_q : inst_sram_rdata;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: next-PC select, IF PC/valid and the decode handshake.
// Optional instruction holding register is built when IF_INST_BUF_EN is defined.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_wen,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    br_bus_t     br;
    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        fetch_req;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    logic        fs_valid_q;
    logic [31:0] fs_pc_q;

    assign br          = br_bus_t'(br_bus);
    assign to_fs_valid = ~reset;
    assign fs_ready_go = 1'b1;
    assign fs_allowin  = !fs_valid_q || (fs_ready_go && ds_allowin);
    assign fetch_req   = to_fs_valid && fs_allowin;

    // A branch seen while stalled never reaches the PC; decode re-asserts it later.
    assign nextpc = br.taken ? br.target : seq_pc_of(fs_pc_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q <= 1'b0;
            fs_pc_q    <= FS_RESET_PC;
        end else if (fetch_req) begin
            fs_valid_q <= 1'b1;
            fs_pc_q    <= nextpc;
        end
    end

`ifdef IF_INST_BUF_EN
    logic fs_first_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_first_q <= 1'b0;
        end else begin
            fs_first_q <= fetch_req;
        end
    end

    if_inst_buf u_inst_buf (
        .clk             (clk),
        .reset           (reset),
        .fs_first        (fs_first_q),
        .fs_valid        (fs_valid_q),
        .ds_allowin      (ds_allowin),
        .inst_sram_rdata (inst_sram_rdata),
        .fs_inst         (fs_inst)
    );
`else
    assign fs_inst = inst_sram_rdata;
`endif

    assign fs_to_ds_valid  = fs_valid_q && fs_ready_go;
    assign fs_to_ds_bus    = {fs_inst, fs_pc_q};

    assign inst_sram_en    = fetch_req;
    assign inst_sram_wen   = 4'h0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, then random traffic against a fetch model.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int n_cmp;
    int n_err;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hbfc0_0100) return 32'h2408_0001;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // With the buffer built the SRAM model turns hostile once the response cycle is over.
`ifdef IF_INST_BUF_EN
    localparam bit CORRUPT = 1'b1;
`else
    localparam bit CORRUPT = 1'b0;
`endif

    initial inst_sram_rdata = 32'h0;
    always @(posedge clk) begin
        if (inst_sram_en)  inst_sram_rdata <= mem(inst_sram_addr);
        else if (CORRUPT)  inst_sram_rdata <= 32'hdeadbeef;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        allow;
        logic        bt;
        logic [31:0] tgt;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        int          chk_buf;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic allow, input logic bt,
                                input logic [31:0] tgt, input logic en, input logic [31:0] addr,
                                input logic v, input logic [31:0] pc, input int cb);
        vec_t r;
        r.rst = rst; r.allow = allow; r.bt = bt; r.tgt = tgt;
        r.exp_en = en; r.exp_addr = addr; r.exp_valid = v; r.exp_pc = pc; r.chk_buf = cb;
        return r;
    endfunction

    task automatic drive(input logic rst, input logic allow, input logic bt, input logic [31:0] tgt);
        @(negedge clk);
        reset      = rst;
        ds_allowin = allow;
        br_bus     = {bt, tgt};
        #1;
    endtask

    vec_t tbl[20];

    initial begin : main
        logic        mv;
        logic [31:0] mpc;
        logic        r_rst, r_allow, r_bt;
        logic [31:0] r_tgt, e_addr;
        logic        e_en;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        ds_allowin = 1'b1;
        br_bus = '0;

        tbl[0]  = mk(1, 1, 0, 32'h0,          0, 32'hbfc0_0000, 0, 32'hbfbf_fffc, -1);
        tbl[1]  = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0000, 0, 32'hbfbf_fffc, -1);
        tbl[2]  = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0004, 1, 32'hbfc0_0000, -1);
        tbl[3]  = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0008, 1, 32'hbfc0_0004, -1);
        tbl[4]  = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_000c, 1, 32'hbfc0_0008, -1);
        tbl[5]  = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0010, 1, 32'hbfc0_000c, -1);
        tbl[6]  = mk(1, 1, 0, 32'h0,          0, 32'hbfc0_0014, 1, 32'hbfc0_0010, -1);
        tbl[7]  = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0000, 0, 32'hbfbf_fffc, -1);
        tbl[8]  = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0004, 1, 32'hbfc0_0000, -1);
        tbl[9]  = mk(0, 1, 1, 32'hbfc0_0100,  1, 32'hbfc0_0100, 1, 32'hbfc0_0004, -1);
        tbl[10] = mk(0, 0, 0, 32'h0,          0, 32'hbfc0_0104, 1, 32'hbfc0_0100, -1);
        tbl[11] = mk(0, 0, 1, 32'hbfc0_0200,  0, 32'hbfc0_0200, 1, 32'hbfc0_0100, 1);
        tbl[12] = mk(0, 0, 0, 32'h0,          0, 32'hbfc0_0104, 1, 32'hbfc0_0100, 1);
        tbl[13] = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0104, 1, 32'hbfc0_0100, 1);
        tbl[14] = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0108, 1, 32'hbfc0_0104, 0);
        tbl[15] = mk(0, 0, 0, 32'h0,          0, 32'hbfc0_010c, 1, 32'hbfc0_0108, 0);
        tbl[16] = mk(0, 0, 0, 32'h0,          0, 32'hbfc0_010c, 1, 32'hbfc0_0108, 1);
        tbl[17] = mk(1, 0, 0, 32'h0,          0, 32'hbfc0_010c, 1, 32'hbfc0_0108, 1);
        tbl[18] = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0000, 0, 32'hbfbf_fffc, 0);
        tbl[19] = mk(0, 1, 0, 32'h0,          1, 32'hbfc0_0004, 1, 32'hbfc0_0000, -1);

        drive(1, 1, 0, 32'h0);
        drive(1, 1, 0, 32'h0);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].allow, tbl[i].bt, tbl[i].tgt);
            check($sformatf("v%0d.en", i),    {31'h0, inst_sram_en},   {31'h0, tbl[i].exp_en});
            check($sformatf("v%0d.addr", i),  inst_sram_addr,          tbl[i].exp_addr);
            check($sformatf("v%0d.valid", i), {31'h0, fs_to_ds_valid}, {31'h0, tbl[i].exp_valid});
            check($sformatf("v%0d.pc", i),    fs_to_ds_bus[31:0],      tbl[i].exp_pc);
            if (tbl[i].exp_valid)
                check($sformatf("v%0d.inst", i), fs_to_ds_bus[63:32], mem(tbl[i].exp_pc));
            if (i == 0) begin
                check("wen_tied", {28'h0, inst_sram_wen}, 32'h0);
                check("wdata_tied", inst_sram_wdata, 32'h0);
            end
`ifdef IF_INST_BUF_EN
            if (tbl[i].chk_buf >= 0)
                check($sformatf("v%0d.buf_valid", i), {31'h0, dut.u_inst_buf.buf_valid_q},
                      tbl[i].chk_buf[31:0]);
`endif
        end

        // Random phase: the model tracks the architectural fetch stream, not the RTL.
        drive(1, 1, 0, 32'h0);
        mv  = 1'b0;
        mpc = 32'hbfbf_fffc;
        for (int c = 0; c < 3000; c++) begin
            r_rst   = ($urandom_range(0, 99) < 2);
            r_allow = ($urandom_range(0, 99) < 65);
            r_bt    = ($urandom_range(0, 99) < 20);
            r_tgt   = $urandom & 32'hffff_fffc;
            drive(r_rst, r_allow, r_bt, r_tgt);

            e_en   = !r_rst && (!mv || r_allow);
            e_addr = r_bt ? r_tgt : mpc + 32'd4;
            check("rnd.en",    {31'h0, inst_sram_en},   {31'h0, e_en});
            check("rnd.addr",  inst_sram_addr,          e_addr);
            check("rnd.valid", {31'h0, fs_to_ds_valid}, {31'h0, mv});
            check("rnd.pc",    fs_to_ds_bus[31:0],      mpc);
            if (mv) check("rnd.inst", fs_to_ds_bus[63:32], mem(mpc));

            if (r_rst) begin
                mv  = 1'b0;
                mpc = 32'hbfbf_fffc;
            end else if (e_en) begin
                mv  = 1'b1;
                mpc = e_addr;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
